// File: rtl/spi_master_gen.sv
// spi_master_gen: SPI master with per-transfer mode, bit order, divider and slave select.
// Define SPI_MASTER_GEN_LOOPBACK_EN to add a loopback input that feeds mosi into the receive path.
module spi_master_gen #(
  parameter int DW   = 8,
  parameter int NCS  = 1,
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cpol,
  input  logic            cpha,
  input  logic            msb_first,
  input  logic [DIVW-1:0] div,
  input  logic [2:0]      cs_sel,
  input  logic [DW-1:0]   tdata,
  input  logic            miso,
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
  input  logic            loopback,
`endif
  output logic            sck,
  output logic            mosi,
  output logic [NCS-1:0]  ss_n,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   rdata
);
  // state | meaning
  // IDLE  | waiting for start; sck parked at last latched cpol, mosi high
  // LEAD  | slave selected, one half-period before the first sck edge
  // XFER  | 2*DW sck edges, one per half-period
  // TRAIL | one half-period hold, then deselect and pulse done
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  localparam int            EW        = $clog2(2*DW);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DW-1);
  localparam logic [3:0]    NCS_L     = 4'(NCS);

  state_t          state;
  logic [DIVW-1:0] hcnt;
  logic [DIVW-1:0] div_l;
  logic [EW-1:0]   ecnt;
  logic            cpha_l;
  logic            msb_l;
  logic [DW-1:0]   tx_sr;
  logic [DW-1:0]   rx_sr;
  logic [NCS-1:0]  ss_sel;
  logic            accept;
  logic            rx_bit;
  logic            tx_bit;
  logic            lead_edge;
  logic            first_bit;
  logic [DW-1:0]   first_rest;
  logic [DW-1:0]   tx_shift;
  logic [DW-1:0]   rx_next;

  always_comb begin
    ss_sel = '1;
    for (int i = 0; i < NCS; i++)
      if (cs_sel == 3'(i)) ss_sel[i] = 1'b0;
  end

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
  assign rx_bit = loopback ? mosi : miso;
`else
  assign rx_bit = miso;
`endif

  assign accept     = (state == IDLE) && start && ({1'b0, cs_sel} < NCS_L);
  assign lead_edge  = ~ecnt[0];
  assign tx_bit     = msb_l ? tx_sr[DW-1] : tx_sr[0];
  assign tx_shift   = msb_l ? (tx_sr << 1) : (tx_sr >> 1);
  assign rx_next    = msb_l ? {rx_sr[DW-2:0], rx_bit} : {rx_bit, rx_sr[DW-1:1]};
  assign first_bit  = msb_first ? tdata[DW-1] : tdata[0];
  assign first_rest = msb_first ? (tdata << 1) : (tdata >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hcnt   <= '0;
      div_l  <= '0;
      ecnt   <= '0;
      cpha_l <= 1'b0;
      msb_l  <= 1'b0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      sck    <= 1'b0;
      mosi   <= 1'b1;
      ss_n   <= '1;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= LEAD;
            hcnt   <= div;
            div_l  <= div;
            ecnt   <= '0;
            cpha_l <= cpha;
            msb_l  <= msb_first;
            sck    <= cpol;
            ss_n   <= ss_sel;
            busy   <= 1'b1;
            // cpha=0 presents the first bit during LEAD; cpha=1 waits for the first leading edge
            if (cpha) begin
              tx_sr <= tdata;
              mosi  <= 1'b1;
            end else begin
              tx_sr <= first_rest;
              mosi  <= first_bit;
            end
          end
        end
        LEAD: begin
          if (hcnt == '0) begin
            state <= XFER;
            hcnt  <= div_l;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        XFER: begin
          if (hcnt == '0) begin
            hcnt <= div_l;
            sck  <= ~sck;
            ecnt <= ecnt + 1'b1;
            // sample edge is leading for cpha=0, trailing for cpha=1; the other edge shifts mosi
            if (lead_edge ^ cpha_l) begin
              rx_sr <= rx_next;
            end else if (ecnt != LAST_EDGE) begin
              mosi  <= tx_bit;
              tx_sr <= tx_shift;
            end
            if (ecnt == LAST_EDGE) state <= TRAIL;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        TRAIL: begin
          if (hcnt == '0) begin
            state <= IDLE;
            ss_n  <= '1;
            mosi  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            rdata <= rx_sr;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_master_gen.md
SPI_MASTER_GEN -- requirements
Module: spi_master_gen

Interface
REQ-001 Parameter DW, default 8, transfer word width in bits (2..32).
REQ-002 Parameter NCS, default 1, number of slave-select outputs (1..8).
REQ-003 Parameter DIVW, default 8, width of the clock-divider input.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  transfer request; sampled in IDLE only.
REQ-007 cpol  input  1  SCK idle level.
REQ-008 cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge.
REQ-009 msb_first  input  1  1 = MSB first; 0 = LSB first.
REQ-010 div  input  DIVW  half-period select: H = div+1 clk cycles.
REQ-011 cs_sel  input  3  slave-select index.
REQ-012 tdata  input  DW  transmit word.
REQ-013 miso  input  1  serial data from slave.
REQ-014 sck  output  1  serial clock.
REQ-015 mosi  output  1  serial data to slave.
REQ-016 ss_n  output  NCS  active-low slave selects.
REQ-017 busy  output  1  high from the cycle after accepted start until done.
REQ-018 done  output  1  one-cycle pulse at transfer end.
REQ-019 rdata  output  DW  received word.

Function
REQ-020 States: IDLE, LEAD, XFER, TRAIL. IDLE->LEAD on start=1 with cs_sel<NCS; LEAD->XFER after H cycles; XFER->TRAIL after 2*DW half-periods; TRAIL->IDLE after H cycles.
REQ-021 On accepted start, cpol, cpha, msb_first, div, cs_sel and tdata are latched; later input changes do not affect the running transfer.
REQ-022 start with cs_sel>=NCS is ignored: no state change, no busy, no done.
REQ-023 start while busy is ignored.
REQ-024 ss_n[cs_sel] is low from LEAD entry to TRAIL exit; all other ss_n bits stay high.
REQ-025 sck equals latched cpol outside XFER and toggles once every H cycles in XFER, giving 2*DW edges.
REQ-026 cpha=0: the first bit is on mosi at LEAD entry; miso is sampled on each leading edge; mosi advances on each trailing edge.
REQ-027 cpha=1: mosi advances on each leading edge, the first bit appearing at the first leading edge; miso is sampled on each trailing edge.
REQ-028 Bit order follows latched msb_first for both mosi and miso assembly.
REQ-029 mosi is 1 outside LEAD/XFER/TRAIL.
REQ-030 The miso sample is taken in the clk cycle in which the sck register toggles.
REQ-031 Counting the accepted start edge as cycle 0, done pulses in cycle (2*DW+2)*H+1.
REQ-032 rdata updates in the done cycle and holds until the next done.
REQ-033 start=1 in the done cycle is accepted, allowing back-to-back transfers.

Reset
REQ-034 rst=1 at any clock edge, including mid-transfer, forces IDLE.
REQ-035 rst=1 forces sck=0, mosi=1, ss_n=all ones, busy=0, done=0 and rdata=0.
REQ-036 A transfer aborted by reset produces no done pulse.

Configuration
REQ-037 Macro SPI_MASTER_GEN_LOOPBACK_EN.
REQ-038 When SPI_MASTER_GEN_LOOPBACK_EN is defined, add input loopback (1 bit); when loopback=1, the internal sampled data is mosi and pin miso is ignored.
REQ-039 When SPI_MASTER_GEN_LOOPBACK_EN is undefined, there is no loopback port and miso is always used.

Verification
REQ-040 DW=8, mode 0, div=0, tdata=0xA5, miso tied to mosi -> rdata=0xA5; done in cycle 19; 16 sck edges; ss_n[0] low for cycles 1-18.
REQ-041 Mode 3, msb_first=0, div=3, tdata=0x3C, slave returns 0x81 LSB first -> rdata=0x81; sck idles 1; done in cycle 73.
REQ-042 NCS=4, cs_sel=2 -> only ss_n[2] toggles; cs_sel=5 -> start ignored, busy stays 0.
REQ-043 start pulsed during XFER with different tdata -> first word unaffected; exactly one done pulse.
REQ-044 rst asserted at cycle 8 of a transfer -> next cycle sck=cpol reset value 0, ss_n=all ones, busy=0; no done pulse.
REQ-045 With SPI_MASTER_GEN_LOOPBACK_EN defined, loopback=1, miso=0, tdata=0x5A -> rdata=0x5A.
